// File: rtl/fir_sample_feeder_if.sv
// Upstream sample handshake into the FIR sample feeder.
// The master side drives samples; the slave side (the feeder) returns ready.
interface fir_sample_feeder_if #(
   parameter int DW = 8
);
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fir_sample_feeder.sv
// Buffers upstream samples and releases exactly one to the FIR every PERIOD clocks.
// Build option FEEDER_HOLD_LAST_EN: repeat the last sample on underrun instead of sending zero.
module fir_sample_feeder #(
   parameter int DW     = 8,
   parameter int DEPTH  = 8,
   parameter int AW     = 3,
   parameter int PERIOD = 9
) (
   input  logic          clk,
   input  logic          rst,
   fir_sample_feeder_if.slave s,
   output logic [DW-1:0] din,
   output logic          strobe,
   output logic [AW:0]   level,
   output logic          underrun,
   input  logic          clr_flags
);
   localparam int FW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic [FW-1:0] fcnt_reg;
   logic [DW-1:0] din_reg;
   logic          strobe_reg;
   logic          underrun_reg;
   logic [DW-1:0] filler;
   logic          tick;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;

   assign tick  = (fcnt_reg == FW'(PERIOD - 1));
   assign empty = (count_reg == '0);
   assign full  = (count_reg == (AW+1)'(DEPTH));
   // Writes are blocked while reset is held so no stale sample survives it.
   assign push  = rst & s.s_valid & ~full;
   assign pop   = tick & ~empty;

   assign s.s_ready = ~full;

`ifdef FEEDER_HOLD_LAST_EN
   assign filler = din_reg;
`else
   assign filler = '0;
`endif

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= s.s_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fcnt_reg     <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         din_reg      <= '0;
         strobe_reg   <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         fcnt_reg   <= tick ? '0 : fcnt_reg + FW'(1);
         strobe_reg <= tick;
         count_reg  <= count_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop) begin
            din_reg    <= mem[rd_ptr_reg];
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end else if (tick) begin
            din_reg <= filler;
         end
         // An empty tick in the same clock as a clear leaves the flag set.
         if (tick && empty)
            underrun_reg <= 1'b1;
         else if (clr_flags)
            underrun_reg <= 1'b0;
      end
   end

   assign din      = din_reg;
   assign strobe   = strobe_reg;
   assign level    = count_reg;
   assign underrun = underrun_reg;
endmodule
